// File: rtl/armleocpu_ptw_multilevel_if.sv
// Read-only memory port between the page table walker (master) and the cache/bus arbiter (slave).
interface armleocpu_ptw_multilevel_if #(
    parameter int PA_W  = 34,
    parameter int PTE_W = 32
);
    logic [PA_W-1:0]  m_address;
    logic             m_read;
    logic             m_waitrequest;
    logic             m_readdatavalid;
    logic [PTE_W-1:0] m_readdata;
    logic             m_response;

    modport master (
        output m_address, m_read,
        input  m_waitrequest, m_readdatavalid, m_readdata, m_response
    );

    modport slave (
        input  m_address, m_read,
        output m_waitrequest, m_readdatavalid, m_readdata, m_response
    );
endinterface

// File: rtl/armleocpu_ptw_multilevel.sv
// Multilevel RISC-V style page table walker over one read-only memory port.
// Optional feature: define ARMLEOCPU_PTW_AD_CHECK_EN to pagefault on leaf PTEs with A=0.
module armleocpu_ptw_multilevel #(
    parameter int LEVELS = 2,
    parameter int VPN_W  = 10,
    parameter int PTE_W  = 32,
    parameter int PPN_W  = 22,
    parameter int PA_W   = 34,
    localparam int VA_W  = 12 + LEVELS * VPN_W
) (
    input  logic                     clk,
    input  logic                     async_rst_n,
    input  logic                     resolve_request,
    input  logic [VA_W-1:0]          resolve_virtual_address,
    input  logic                     satp_mode,
    input  logic [PPN_W-1:0]         satp_ppn,
    output logic                     resolve_done,
    output logic                     resolve_pagefault,
    output logic                     resolve_accessfault,
    output logic [PA_W-1:0]          resolve_physical_address,
    output logic [7:0]               resolve_access_bits,
    armleocpu_ptw_multilevel_if.master mem
);
    localparam int PTE_B  = PTE_W / 8;
    localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int WIDE_W = PA_W + PPN_W + VA_W + 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    logic [LVL_W-1:0]  level;
    logic [VA_W-1:0]   va_q;

    logic [PPN_W-1:0]  pte_ppn;
    logic [PPN_W-1:0]  low_mask;
    logic [VA_W-1:0]   va_mask;
    logic              pte_v, pte_r, pte_w, pte_x, pte_a, pte_leaf;
    logic              page_fault, descend;
    logic [WIDE_W-1:0] pa_wide, va_wide;
    logic [PA_W-1:0]   leaf_pa, bare_pa;
    logic              unused_pte_bits;

    // Byte address of the PTE selected by VPN[lvl] inside the table at ppn.
    function automatic logic [PA_W-1:0] pte_address(input logic [PPN_W-1:0] ppn,
                                                    input logic [VA_W-1:0]  va,
                                                    input logic [LVL_W-1:0] lvl);
        logic [WIDE_W-1:0] sum;
        sum = (WIDE_W'(ppn) << 12)
            + WIDE_W'(va[12 + int'(lvl) * VPN_W +: VPN_W]) * WIDE_W'(PTE_B);
        return sum[PA_W-1:0];
    endfunction

    assign unused_pte_bits = ^mem.m_readdata;

    always_comb begin
        // NOTE: every signal gets a default before any condition, so no path infers a latch.
        pte_ppn    = mem.m_readdata[PPN_W+9:10];
        pte_v      = mem.m_readdata[0];
        pte_r      = mem.m_readdata[1];
        pte_w      = mem.m_readdata[2];
        pte_x      = mem.m_readdata[3];
        pte_a      = mem.m_readdata[6];
        pte_leaf   = pte_r | pte_x;
        low_mask   = '0;
        va_mask    = '0;
        page_fault = 1'b0;
        descend    = 1'b0;

        // Superpage: PPN fields below the current level come from the VA instead.
        for (int i = 0; i < PPN_W; i++) low_mask[i] = (i < int'(level) * VPN_W);
        for (int i = 0; i < VA_W; i++)  va_mask[i]  = (i < 12 + int'(level) * VPN_W);

        if (!pte_v || (pte_w && !pte_r)) page_fault = 1'b1;
        else if (pte_leaf && (|(pte_ppn & low_mask))) page_fault = 1'b1;
`ifdef ARMLEOCPU_PTW_AD_CHECK_EN
        else if (pte_leaf && !pte_a) page_fault = 1'b1;
`endif
        else if (!pte_leaf) begin
            if (level == '0) page_fault = 1'b1;
            else             descend    = 1'b1;
        end

        pa_wide = (WIDE_W'(pte_ppn & ~low_mask) << 12) | WIDE_W'(va_q & va_mask);
        leaf_pa = pa_wide[PA_W-1:0];
        va_wide = WIDE_W'(resolve_virtual_address);
        bare_pa = va_wide[PA_W-1:0];
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state                    <= IDLE;
            level                    <= '0;
            va_q                     <= '0;
            mem.m_read               <= 1'b0;
            mem.m_address            <= '0;
            resolve_done             <= 1'b0;
            resolve_pagefault        <= 1'b0;
            resolve_accessfault      <= 1'b0;
            resolve_physical_address <= '0;
            resolve_access_bits      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (resolve_request) begin
                        va_q  <= resolve_virtual_address;
                        level <= LVL_W'(LEVELS - 1);
                        if (!satp_mode) begin
                            resolve_pagefault        <= 1'b0;
                            resolve_accessfault      <= 1'b0;
                            resolve_physical_address <= bare_pa;
                            resolve_access_bits      <= '0;
                            resolve_done             <= 1'b1;
                            state                    <= DONE;
                        end else begin
                            mem.m_read    <= 1'b1;
                            mem.m_address <= pte_address(satp_ppn, resolve_virtual_address,
                                                         LVL_W'(LEVELS - 1));
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!mem.m_waitrequest) begin
                        mem.m_read <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.m_readdatavalid) begin
                        resolve_access_bits <= mem.m_readdata[7:0];
                        if (mem.m_response) begin
                            resolve_accessfault      <= 1'b1;
                            resolve_pagefault        <= 1'b0;
                            resolve_physical_address <= '0;
                            resolve_done             <= 1'b1;
                            state                    <= DONE;
                        end else if (descend) begin
                            level         <= level - 1'b1;
                            mem.m_read    <= 1'b1;
                            mem.m_address <= pte_address(pte_ppn, va_q, level - 1'b1);
                            state         <= ISSUE;
                        end else begin
                            resolve_accessfault      <= 1'b0;
                            resolve_pagefault        <= page_fault;
                            resolve_physical_address <= page_fault ? '0 : leaf_pa;
                            resolve_done             <= 1'b1;
                            state                    <= DONE;
                        end
                    end
                end
                DONE: begin
                    resolve_done <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_armleocpu_ptw_multilevel.sv
// Randomised and directed bench for armleocpu_ptw_multilevel against a walk-level reference model.
module tb_armleocpu_ptw_multilevel;
    logic        clk;
    logic        async_rst_n;
    logic        resolve_request;
    logic [31:0] resolve_virtual_address;
    logic        satp_mode;
    logic [21:0] satp_ppn;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [33:0] resolve_physical_address;
    logic [7:0]  resolve_access_bits;

    armleocpu_ptw_multilevel_if #(.PA_W(34), .PTE_W(32)) mem_if ();

    armleocpu_ptw_multilevel dut (
        .clk                      (clk),
        .async_rst_n              (async_rst_n),
        .resolve_request          (resolve_request),
        .resolve_virtual_address  (resolve_virtual_address),
        .satp_mode                (satp_mode),
        .satp_ppn                 (satp_ppn),
        .resolve_done             (resolve_done),
        .resolve_pagefault        (resolve_pagefault),
        .resolve_accessfault      (resolve_accessfault),
        .resolve_physical_address (resolve_physical_address),
        .resolve_access_bits      (resolve_access_bits),
        .mem                      (mem_if)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0]     pte_mem [longint unsigned];
    longint unsigned exp_reads[$];
    longint unsigned read_log[$];
    int              cfg_wait, cfg_delay;
    bit              cfg_err;
    int              addr_unstable;
    int              rphase, rleft;
    longint unsigned raddr;

`ifdef ARMLEOCPU_PTW_AD_CHECK_EN
    localparam bit AD_CHECK = 1'b1;
`else
    localparam bit AD_CHECK = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_read(input longint unsigned a);
        return pte_mem.exists(a) ? pte_mem[a] : 32'h0;
    endfunction

    // Memory slave: cfg_wait stall cycles per read, then data cfg_delay cycles after the WAIT entry.
    initial begin
        rphase = 0;
        rleft  = 0;
        raddr  = 0;
        mem_if.m_waitrequest   = 1'b1;
        mem_if.m_readdatavalid = 1'b0;
        mem_if.m_readdata      = '0;
        mem_if.m_response      = 1'b0;
        forever begin
            @(negedge clk);
            mem_if.m_readdatavalid = 1'b0;
            mem_if.m_response      = 1'b0;
            if (!async_rst_n) begin
                rphase = 0;
                mem_if.m_waitrequest = 1'b1;
            end else begin
                case (rphase)
                    0: if (mem_if.m_read === 1'b1) begin
                        raddr = 64'(mem_if.m_address);
                        read_log.push_back(raddr);
                        if (cfg_wait == 0) begin
                            mem_if.m_waitrequest = 1'b0;
                            rleft  = cfg_delay;
                            rphase = 2;
                        end else begin
                            mem_if.m_waitrequest = 1'b1;
                            rleft  = cfg_wait - 1;
                            rphase = 1;
                        end
                    end
                    1: begin
                        if (mem_if.m_read !== 1'b1 || 64'(mem_if.m_address) != raddr) addr_unstable++;
                        if (rleft == 0) begin
                            mem_if.m_waitrequest = 1'b0;
                            rleft  = cfg_delay;
                            rphase = 2;
                        end else rleft--;
                    end
                    default: begin
                        mem_if.m_waitrequest = 1'b1;
                        if (rleft == 0) begin
                            mem_if.m_readdatavalid = 1'b1;
                            mem_if.m_readdata      = mem_read(raddr);
                            mem_if.m_response      = cfg_err;
                            rphase = 0;
                        end else rleft--;
                    end
                endcase
            end
        end
    end

    // Reference model: walks the tables in plain arithmetic, fills exp_reads with the expected addresses.
    task automatic model_walk(input logic [31:0] va, input bit mode, input logic [21:0] ppn, input bit err,
                              output bit pf, output bit af, output logic [33:0] pa, output logic [7:0] bits);
        longint unsigned a, addr, p, pte_ppn, span, va64;
        pf = 0; af = 0; pa = 0; bits = 0;
        exp_reads.delete();
        va64 = 64'(va);
        if (!mode) begin
            pa = 34'(va64);
            return;
        end
        a = 64'(ppn) * 4096;
        for (int lvl = 1; lvl >= 0; lvl--) begin
            addr = (a + ((va64 >> (12 + 10 * lvl)) & 64'h3FF) * 4) % (64'd1 << 34);
            exp_reads.push_back(addr);
            p    = 64'(mem_read(addr));
            bits = p[7:0];
            if (err) begin af = 1; return; end
            pte_ppn = p >> 10;
            span    = 64'd1 << (10 * lvl);
            if (p[0] == 0 || (p[2] == 1 && p[1] == 0)) begin pf = 1; return; end
            if (p[1] == 1 || p[3] == 1) begin
                if (pte_ppn % span != 0) begin pf = 1; return; end
                if (AD_CHECK && p[6] == 0) begin pf = 1; return; end
                pa = 34'((pte_ppn / span * span) * 4096 + va64 % (span * 4096));
                return;
            end
            if (lvl == 0) begin pf = 1; return; end
            a = pte_ppn * 4096;
        end
    endtask

    task automatic do_walk(input string name, input logic [31:0] va, input bit mode, input logic [21:0] ppn,
                           input int w, input int d, input bit e, input bit hold);
        bit          exp_pf, exp_af, seen;
        logic [33:0] exp_pa;
        logic [7:0]  exp_bits;
        int          exp_lat, cycles;
        model_walk(va, mode, ppn, e, exp_pf, exp_af, exp_pa, exp_bits);
        exp_lat = mode ? exp_reads.size() * (2 + w + d) + 1 : 1;
        cfg_wait = w; cfg_delay = d; cfg_err = e;
        read_log.delete();
        addr_unstable = 0;
        resolve_virtual_address = va;
        satp_mode       = mode;
        satp_ppn        = ppn;
        resolve_request = 1'b1;
        cycles = 0;
        seen   = 0;
        while (!seen && cycles < 300) begin
            @(negedge clk);
            cycles++;
            seen = (resolve_done === 1'b1);
        end
        if (!hold) resolve_request = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done: none within %0d cycles", name, cycles);
            return;
        end
        checks++;
        if (cycles != exp_lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, cycles, exp_lat); end
        checks++;
        if (resolve_pagefault !== exp_pf) begin errors++; $display("FAIL %s pagefault: got %b want %b", name, resolve_pagefault, exp_pf); end
        checks++;
        if (resolve_accessfault !== exp_af) begin errors++; $display("FAIL %s accessfault: got %b want %b", name, resolve_accessfault, exp_af); end
        checks++;
        if (resolve_physical_address !== exp_pa) begin errors++; $display("FAIL %s pa: got %h want %h", name, resolve_physical_address, exp_pa); end
        if (mode && !exp_af) begin
            checks++;
            if (resolve_access_bits !== exp_bits) begin errors++; $display("FAIL %s access_bits: got %h want %h", name, resolve_access_bits, exp_bits); end
        end
        checks++;
        if (read_log.size() != exp_reads.size()) begin
            errors++;
            $display("FAIL %s read count: got %0d want %0d", name, read_log.size(), exp_reads.size());
        end else begin
            foreach (exp_reads[i]) begin
                checks++;
                if (read_log[i] != exp_reads[i]) begin errors++; $display("FAIL %s read[%0d] addr: got %h want %h", name, i, read_log[i], exp_reads[i]); end
            end
        end
        checks++;
        if (addr_unstable != 0) begin errors++; $display("FAIL %s stall stability: %0d changes want 0", name, addr_unstable); end
        @(negedge clk);
        checks++;
        if (resolve_done !== 1'b0) begin errors++; $display("FAIL %s done pulse width: got %b want 0", name, resolve_done); end
    endtask

    function automatic logic [31:0] gen_pte(input int lvl);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return {r[31:10], 2'b00, 8'h01};
            2:       return {r[31:20], (lvl == 1) ? 10'h0 : r[19:10], 2'b00, r[7:4], r[3], r[2], 2'b11};
            default: return {r[31:10], 2'b00, 8'hCF};
        endcase
    endfunction

    task automatic test_reset();
        async_rst_n = 1'b0;
        resolve_request = 1'b0;
        resolve_virtual_address = '0;
        satp_mode = 1'b0;
        satp_ppn  = '0;
        cfg_wait = 0; cfg_delay = 0; cfg_err = 0;
        repeat (3) @(negedge clk);
        async_rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_if.m_read, resolve_done, resolve_pagefault, resolve_accessfault} !== 4'b0) begin
            errors++;
            $display("FAIL reset flags: read/done/pf/af got %b want 0000",
                     {mem_if.m_read, resolve_done, resolve_pagefault, resolve_accessfault});
        end
        checks++;
        if (mem_if.m_address !== '0 || resolve_physical_address !== '0 || resolve_access_bits !== '0) begin
            errors++;
            $display("FAIL reset values: addr %h pa %h bits %h want all 0", mem_if.m_address, resolve_physical_address, resolve_access_bits);
        end
    endtask

    task automatic test_directed();
        pte_mem.delete();
        pte_mem[64'h1F00] = 32'h0040000F;
        do_walk("megapage", 32'hF00A1FFF, 1'b1, 22'h1, 0, 0, 1'b0, 1'b0);
        pte_mem[64'h1F00] = 32'h00400000;
        do_walk("invalid", 32'hF00A1FFF, 1'b1, 22'h1, 0, 0, 1'b0, 1'b0);
        pte_mem[64'h1F00] = 32'h0040040F;
        do_walk("misaligned", 32'hF00A1FFF, 1'b1, 22'h1, 0, 0, 1'b0, 1'b0);
        pte_mem[64'h1F00] = 32'h00000801;
        pte_mem[64'h2284] = 32'h048D14CF;
        do_walk("two_level", 32'hF00A1FFF, 1'b1, 22'h1, 0, 0, 1'b0, 1'b0);
        pte_mem[64'h2284] = 32'h048D1401;
        do_walk("leaf_missing", 32'hF00A1FFF, 1'b1, 22'h1, 0, 1, 1'b0, 1'b0);
        pte_mem[64'h2284] = 32'h048D14C5;
        do_walk("write_only", 32'hF00A1FFF, 1'b1, 22'h1, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_bus_error();
        pte_mem.delete();
        pte_mem[64'h1F00] = 32'h0040000F;
        do_walk("wait_accessfault", 32'hF00A1FFF, 1'b1, 22'h1, 3, 0, 1'b1, 1'b0);
    endtask

    task automatic test_bare();
        do_walk("bare", 32'hF00A1FFF, 1'b0, 22'h1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        pte_mem.delete();
        pte_mem[64'h1F00] = 32'h00000801;
        pte_mem[64'h2284] = 32'h048D14CF;
        do_walk("b2b_first", 32'hF00A1FFF, 1'b1, 22'h1, 0, 0, 1'b0, 1'b1);
        do_walk("b2b_second", 32'hF00A1FFF, 1'b1, 22'h1, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midwalk(input string name, input int w);
        int dones;
        pte_mem.delete();
        pte_mem[64'h1F00] = 32'h0040000F;
        cfg_wait = w; cfg_delay = 30; cfg_err = 1'b0;
        resolve_virtual_address = 32'hF00A1FFF;
        satp_mode = 1'b1;
        satp_ppn  = 22'h1;
        resolve_request = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        async_rst_n = 1'b0;
        resolve_request = 1'b0;
        #1;
        checks++;
        if (mem_if.m_read !== 1'b0 || resolve_done !== 1'b0) begin
            errors++;
            $display("FAIL %s abort: read %b done %b want 0 0", name, mem_if.m_read, resolve_done);
        end
        dones = 0;
        repeat (2) @(negedge clk);
        async_rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (resolve_done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL %s spurious done: got %0d pulses want 0", name, dones); end
        pte_mem[64'h1F00] = 32'h00000801;
        pte_mem[64'h2284] = 32'h048D14CF;
        do_walk({name, "_after"}, 32'hF00A1FFF, 1'b1, 22'h1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0]     va, p1;
        logic [21:0]     ppn;
        bit              mode;
        longint unsigned l1, l0;
        for (int it = 0; it < 40; it++) begin
            va   = $urandom;
            ppn  = 22'($urandom);
            mode = ($urandom_range(0, 5) != 0);
            pte_mem.delete();
            l1 = (64'(ppn) * 4096 + 64'(va[31:22]) * 4) % (64'd1 << 34);
            p1 = gen_pte(1);
            pte_mem[l1] = p1;
            if (p1[0] && !p1[1] && !p1[3]) begin
                l0 = (64'(p1[31:10]) * 4096 + 64'(va[21:12]) * 4) % (64'd1 << 34);
                pte_mem[l0] = gen_pte(0);
            end
            do_walk($sformatf("random%0d", it), va, mode, ppn, $urandom_range(0, 2), $urandom_range(0, 2),
                    ($urandom_range(0, 7) == 0), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bus_error();
        test_bare();
        test_back_to_back();
        test_reset_midwalk("reset_in_issue", 10);
        test_reset_midwalk("reset_in_wait", 0);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
